macro_id_monitor: RTL and testbench
===================================

Name: macro_id_monitor

Overview:
- Receive-side counterpart of the tile identification macro.
- In each 2x2 tile it watches the north, east and west IO input buses. Each neighbour drives a one-hot pattern on its bus, where bit n set means neighbour number n.
- After a start command it waits a settle time, requires each bus to hold a stable value, decodes each one-hot pattern to a neighbour number, and reports the IDs plus error and timeout status.
- Used in the 2x2 simulation and bring-up to prove tile-to-tile wiring and orientation.

Parameters:
- SETTLE_CYCLES, 4, cycles waited after start before sampling begins (1..255).
- STABLE_CYCLES, 3, consecutive identical samples needed to lock a side (1..15).
- TIMEOUT_CYCLES, 64, maximum cycles in CHECK before giving up (STABLE_CYCLES..1023).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin identification.
- clear  in  1  synchronous abort; returns to IDLE and clears results.
- IO_north_i  in  10  north neighbour pattern.
- IO_east_i  in  14  east neighbour pattern.
- IO_west_i  in  14  west neighbour pattern.
- busy  out  1  high in SETTLE or CHECK.
- done  out  1  high in DONE.
- timeout  out  1  the last run ended by timeout.
- north_id / east_id / west_id  out  4 each  decoded neighbour number, 0..8.
- north_vld / east_vld / west_vld  out  1 each  side locked with a legal pattern.
- north_err / east_err / west_err  out  1 each  side locked with an illegal pattern.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Inputs are in the clk domain and are registered once, with no synchronizer.
- Legal pattern: bits [8:0] contain exactly one 1 and every bit above 8 is 0 (north bit 9; east/west bits 13:9).
  - The ID is the index of the set bit.
  - Otherwise the side is illegal: zero-hot, multi-hot, or a high bit set. An illegal side reports id=0.
- FSM states and transitions:
  - IDLE: start -> SETTLE and load the settle counter with SETTLE_CYCLES.
  - SETTLE: decrement each cycle. On the edge where the counter reaches 0 -> CHECK; per-side stability counters and the timeout counter start at 0.
  - CHECK: each side compares its sample with its previous sample.
    - The first sample, or a changed sample, sets that side's count to 1.
    - An equal sample increments the count, saturating at STABLE_CYCLES.
    - A side is locked once its count equals STABLE_CYCLES.
    - A locked side that then changes unlocks and restarts counting.
    - The cycle after all three sides are locked -> DONE.
    - Results are latched from the locked samples: vld = locked AND legal; err = locked AND illegal; timeout = 0.
    - If the timeout counter reaches TIMEOUT_CYCLES first -> DONE with timeout=1. Sides locked at that moment report normally; unlocked sides report vld=0, err=0, id=0.
  - DONE: results hold. start -> SETTLE, clearing results and timeout in the same cycle.
- start is ignored in SETTLE and CHECK.
- clear has priority over start in every state: next state IDLE, all result outputs 0.
- Latency: with constant legal inputs, done rises on the (SETTLE_CYCLES + STABLE_CYCLES + 1)th edge after the edge that samples start. With defaults this is 8 edges.
- Reset asserted mid-run: immediate return to IDLE with reset values.

Decomposition:
- Shared package macro_id_pkg:
  - ID_W = 4.
  - NUM_IDS = 9.
  - State enum {IDLE, SETTLE, CHECK, DONE}.
  - Function onehot_decode returning {legal, id}, shared with the bench's scoreboard.
- One sub-module, macro_id_side #(WIDTH), instantiated three times. Each instance holds the sample register, stability counter and locked/legal/id outputs.
- The top level holds the FSM, the settle and timeout counters, and the result latches.

Test Plan:
- Wiring: north=10'h004, east=14'h0001, west=14'h0008 constant; pulse start -> done on edge 8; north_id=2, east_id=0, west_id=3; all vld=1, err=0, timeout=0.
- Stability: east toggles 0x0002/0x0004 every cycle for 10 cycles, then holds 0x0004 -> done 3 cycles after the hold begins plus 1; east_id=2.
- Errors: north=0, east=14'h0003, west=14'h0200 -> all err=1, all vld=0, ids 0, done=1, timeout=0.
- Timeout: west toggles forever -> done at TIMEOUT_CYCLES into CHECK, timeout=1, west_vld=0, west_err=0; north and east report normally.
- Control: start during CHECK is ignored. clear during SETTLE -> IDLE with busy=0 next cycle. In DONE, start and clear asserted together -> IDLE. rst_n pulled low mid-CHECK -> all outputs 0 immediately.
- Boundary: SETTLE_CYCLES=1, STABLE_CYCLES=1, north=10'h100 -> done on edge 3, north_id=8.

Source files
------------

// File: rtl/macro_id_pkg.sv
// ============================================================================
// macro_id_pkg : shared types and one-hot decode for the tile ID monitor
// Revision     : 1.0
// ============================================================================
`default_nettype none

package macro_id_pkg;

   localparam int ID_W    = 4;
   localparam int NUM_IDS = 9;
   localparam int MAX_W   = 14;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_e;

   typedef struct packed {
      logic            legal;
      logic [ID_W-1:0] id;
   } decode_t;

   // Legal means exactly one of bits [NUM_IDS-1:0] set and nothing above.
   function automatic decode_t onehot_decode(input logic [MAX_W-1:0] pat);
      decode_t    res;
      logic [3:0] ones;
      res  = '0;
      ones = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         if (pat[i]) begin
            ones   = ones + 4'd1;
            res.id = ID_W'(i);
         end
      end
      res.legal = (ones == 4'd1) && (pat[MAX_W-1:NUM_IDS] == '0);
      if (!res.legal) res.id = '0;
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/macro_id_side.sv
// ============================================================================
// macro_id_side : per-bus sample register, stability counter and decoder
// Revision      : 1.0
// ============================================================================
`default_nettype none

module macro_id_side
   import macro_id_pkg::*;
#(
   parameter int WIDTH         = 14,
   parameter int STABLE_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable_i,
   input  logic [WIDTH-1:0] pattern_i,
   output logic            locked_o,
   output logic            legal_o,
   output logic [ID_W-1:0] id_o
);

   localparam int             CNT_W  = 4;
   localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

   logic [WIDTH-1:0] sample_q, sample_d;
   logic [CNT_W-1:0] count_q, count_d;
   decode_t          dec;

   // Outside CHECK the count sits at zero, so the first CHECK sample always
   // starts a fresh run regardless of what the sample register holds.
   always_comb begin
      sample_d = sample_q;
      count_d  = count_q;
      if (!enable_i) begin
         count_d = '0;
      end else begin
         sample_d = pattern_i;
         if ((count_q == '0) || (pattern_i != sample_q)) begin
            count_d = CNT_W'(1);
         end else if (count_q != STABLE) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q <= '0;
         count_q  <= '0;
      end else begin
         sample_q <= sample_d;
         count_q  <= count_d;
      end
   end

   assign dec      = onehot_decode(MAX_W'(sample_q));
   assign locked_o = (count_q == STABLE);
   assign legal_o  = dec.legal;
   assign id_o     = dec.id;

endmodule

`default_nettype wire

// File: rtl/macro_id_monitor.sv
// ============================================================================
// macro_id_monitor : settles, locks and decodes the N/E/W neighbour ID buses
// Revision         : 1.0
// ============================================================================
`default_nettype none

module macro_id_monitor
   import macro_id_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int STABLE_CYCLES  = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            clear,
   input  logic [9:0]      IO_north_i,
   input  logic [13:0]     IO_east_i,
   input  logic [13:0]     IO_west_i,
   output logic            busy,
   output logic            done,
   output logic            timeout,
   output logic [ID_W-1:0] north_id,
   output logic [ID_W-1:0] east_id,
   output logic [ID_W-1:0] west_id,
   output logic            north_vld,
   output logic            east_vld,
   output logic            west_vld,
   output logic            north_err,
   output logic            east_err,
   output logic            west_err
);

   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);
   localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT_CYCLES - 1);

   state_e                  state_q, state_d;
   logic [7:0]              settle_q, settle_d;
   logic [9:0]              tmo_q, tmo_d;
   logic [2:0][ID_W-1:0]    id_q, id_d;
   logic [2:0]              vld_q, vld_d;
   logic [2:0]              err_q, err_d;
   logic                    timeout_q, timeout_d;

   // Side index: 0 = north, 1 = east, 2 = west.
   logic [2:0]              locked;
   logic [2:0]              legal;
   logic [2:0][ID_W-1:0]    side_id;
   logic                    in_check;

   assign in_check = (state_q == CHECK);

   macro_id_side #(.WIDTH(10), .STABLE_CYCLES(STABLE_CYCLES)) u_north (
      .clk(clk), .rst_n(rst_n), .enable_i(in_check), .pattern_i(IO_north_i),
      .locked_o(locked[0]), .legal_o(legal[0]), .id_o(side_id[0])
   );

   macro_id_side #(.WIDTH(14), .STABLE_CYCLES(STABLE_CYCLES)) u_east (
      .clk(clk), .rst_n(rst_n), .enable_i(in_check), .pattern_i(IO_east_i),
      .locked_o(locked[1]), .legal_o(legal[1]), .id_o(side_id[1])
   );

   macro_id_side #(.WIDTH(14), .STABLE_CYCLES(STABLE_CYCLES)) u_west (
      .clk(clk), .rst_n(rst_n), .enable_i(in_check), .pattern_i(IO_west_i),
      .locked_o(locked[2]), .legal_o(legal[2]), .id_o(side_id[2])
   );

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      tmo_d     = tmo_q;
      id_d      = id_q;
      vld_d     = vld_q;
      err_d     = err_q;
      timeout_d = timeout_q;
      if (clear) begin
         state_d   = IDLE;
         settle_d  = '0;
         tmo_d     = '0;
         id_d      = '0;
         vld_d     = '0;
         err_d     = '0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_d   = SETTLE;
                  settle_d  = SETTLE_LD;
                  tmo_d     = '0;
                  id_d      = '0;
                  vld_d     = '0;
                  err_d     = '0;
                  timeout_d = 1'b0;
               end
            end
            SETTLE: begin
               settle_d = settle_q - 8'd1;
               if (settle_q == 8'd1) begin
                  state_d = CHECK;
                  tmo_d   = '0;
               end
            end
            CHECK: begin
               tmo_d = tmo_q + 10'd1;
               // Lock status is judged before this edge's sample lands, so
               // an all-locked bus set wins over a simultaneous timeout.
               if ((&locked) || (tmo_q == TMO_LAST)) begin
                  state_d   = DONE;
                  timeout_d = ~(&locked);
                  for (int s = 0; s < 3; s++) begin
                     id_d[s]  = locked[s] ? side_id[s] : '0;
                     vld_d[s] = locked[s] &  legal[s];
                     err_d[s] = locked[s] & ~legal[s];
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         settle_q  <= '0;
         tmo_q     <= '0;
         id_q      <= '0;
         vld_q     <= '0;
         err_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         tmo_q     <= tmo_d;
         id_q      <= id_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
      end
   end

   assign busy      = (state_q == SETTLE) || (state_q == CHECK);
   assign done      = (state_q == DONE);
   assign timeout   = timeout_q;
   assign north_id  = id_q[0];
   assign east_id   = id_q[1];
   assign west_id   = id_q[2];
   assign north_vld = vld_q[0];
   assign east_vld  = vld_q[1];
   assign west_vld  = vld_q[2];
   assign north_err = err_q[0];
   assign east_err  = err_q[1];
   assign west_err  = err_q[2];

endmodule

`default_nettype wire

// File: tb/tb_macro_id_monitor.sv
// ============================================================================
// tb_macro_id_monitor : table, directed and randomized checks of the monitor
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_macro_id_monitor;

   localparam int S  = 4;
   localparam int T  = 3;
   localparam int TO = 64;

   localparam int P_IDLE   = 0;
   localparam int P_SETTLE = 1;
   localparam int P_CHECK  = 2;
   localparam int P_DONE   = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, clear;
   logic [9:0]  IO_north_i;
   logic [13:0] IO_east_i, IO_west_i;
   logic        busy, done, timeout;
   logic [3:0]  north_id, east_id, west_id;
   logic        north_vld, east_vld, west_vld;
   logic        north_err, east_err, west_err;

   logic        b_start, b_clear;
   logic [9:0]  b_north;
   logic [13:0] b_east, b_west;
   logic        b_busy, b_done, b_timeout;
   logic [3:0]  b_north_id, b_east_id, b_west_id;
   logic        b_north_vld, b_east_vld, b_west_vld;
   logic        b_north_err, b_east_err, b_west_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   macro_id_monitor #(.SETTLE_CYCLES(S), .STABLE_CYCLES(T), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .IO_north_i(IO_north_i), .IO_east_i(IO_east_i), .IO_west_i(IO_west_i),
      .busy(busy), .done(done), .timeout(timeout),
      .north_id(north_id), .east_id(east_id), .west_id(west_id),
      .north_vld(north_vld), .east_vld(east_vld), .west_vld(west_vld),
      .north_err(north_err), .east_err(east_err), .west_err(west_err)
   );

   macro_id_monitor #(.SETTLE_CYCLES(1), .STABLE_CYCLES(1), .TIMEOUT_CYCLES(TO)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .clear(b_clear),
      .IO_north_i(b_north), .IO_east_i(b_east), .IO_west_i(b_west),
      .busy(b_busy), .done(b_done), .timeout(b_timeout),
      .north_id(b_north_id), .east_id(b_east_id), .west_id(b_west_id),
      .north_vld(b_north_vld), .east_vld(b_east_vld), .west_vld(b_west_vld),
      .north_err(b_north_err), .east_err(b_east_err), .west_err(b_west_err)
   );

   // ---------------- reference model ----------------
   int          m_phase, m_left, m_checks;
   logic        m_to;
   logic [13:0] m_hist [3][128];
   logic [3:0]  m_id   [3];
   logic        m_vld  [3];
   logic        m_err  [3];

   function automatic void ref_decode(input logic [13:0] p, output logic legal,
                                      output logic [3:0] id);
      legal = ($countones(p[8:0]) == 1) && (p[13:9] == 5'd0);
      id    = 4'd0;
      if (legal)
         for (int i = 0; i < 9; i++) if (p[i]) id = 4'(i);
   endfunction

   function automatic logic m_locked(input int s);
      if (m_checks < T) return 1'b0;
      for (int j = 1; j < T; j++)
         if (m_hist[s][m_checks-1-j] != m_hist[s][m_checks-1]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_clear_results();
      m_to = 1'b0;
      for (int s = 0; s < 3; s++) begin
         m_id[s] = 4'd0; m_vld[s] = 1'b0; m_err[s] = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_left = 0; m_checks = 0;
      m_clear_results();
   endtask

   task automatic m_finish(input logic to);
      logic       lg;
      logic [3:0] id;
      logic [2:0] lk;
      for (int s = 0; s < 3; s++) lk[s] = m_locked(s);
      m_phase = P_DONE;
      m_to    = to;
      for (int s = 0; s < 3; s++) begin
         if (lk[s]) begin
            ref_decode(m_hist[s][m_checks-1], lg, id);
            m_vld[s] = lg; m_err[s] = ~lg; m_id[s] = id;
         end else begin
            m_vld[s] = 1'b0; m_err[s] = 1'b0; m_id[s] = 4'd0;
         end
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else if (clear) begin
         m_phase = P_IDLE;
         m_clear_results();
      end else begin
         case (m_phase)
            P_IDLE, P_DONE: if (start) begin
               m_phase = P_SETTLE; m_left = S; m_clear_results();
            end
            P_SETTLE: begin
               m_left--;
               if (m_left == 0) begin m_phase = P_CHECK; m_checks = 0; end
            end
            default: begin
               if (m_locked(0) && m_locked(1) && m_locked(2)) m_finish(1'b0);
               else if (m_checks + 1 == TO) m_finish(1'b1);
               if (m_checks < 128) begin
                  m_hist[0][m_checks] = {4'b0, IO_north_i};
                  m_hist[1][m_checks] = IO_east_i;
                  m_hist[2][m_checks] = IO_west_i;
                  m_checks++;
               end
            end
         endcase
      end
   endtask

   function automatic logic [20:0] m_expect();
      return {(m_phase == P_SETTLE) || (m_phase == P_CHECK), m_phase == P_DONE, m_to,
              m_id[0], m_id[1], m_id[2], m_vld[0], m_vld[1], m_vld[2],
              m_err[0], m_err[1], m_err[2]};
   endfunction

   function automatic logic [20:0] pack_a();
      return {busy, done, timeout, north_id, east_id, west_id,
              north_vld, east_vld, west_vld, north_err, east_err, west_err};
   endfunction

   function automatic logic [20:0] pack_b();
      return {b_busy, b_done, b_timeout, b_north_id, b_east_id, b_west_id,
              b_north_vld, b_east_vld, b_west_vld, b_north_err, b_east_err, b_west_err};
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model", 32'(pack_a()), 32'(m_expect()));
   endtask

   task automatic run_until_done(input int budget, output int edges);
      start = 1'b1;
      tick();
      start = 1'b0;
      edges = 0;
      while (!done && edges < budget) begin tick(); edges++; end
   endtask

   function automatic logic [13:0] rand_pat(input int w);
      logic [13:0] p;
      if ($urandom_range(3) != 0) p = 14'(1) << $urandom_range(8);
      else                        p = 14'($urandom) & ((14'(1) << w) - 14'(1));
      return p;
   endfunction

   typedef struct {
      logic [9:0]  n;
      logic [13:0] e, w;
      int          lat;
      logic [3:0]  nid, eid, wid;
      logic [2:0]  vld, err;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          edges;
      logic [13:0] tmp;

      tbl[0] = '{10'h004, 14'h0001, 14'h0008, 8, 4'd2, 4'd0, 4'd3, 3'b111, 3'b000};
      tbl[1] = '{10'h000, 14'h0003, 14'h0200, 8, 4'd0, 4'd0, 4'd0, 3'b000, 3'b111};
      tbl[2] = '{10'h100, 14'h0100, 14'h0080, 8, 4'd8, 4'd8, 4'd7, 3'b111, 3'b000};
      tbl[3] = '{10'h200, 14'h0010, 14'h2000, 8, 4'd0, 4'd4, 4'd0, 3'b010, 3'b101};
      tbl[4] = '{10'h001, 14'h0000, 14'h0101, 8, 4'd0, 4'd0, 4'd0, 3'b100, 3'b011};
      tbl[5] = '{10'h040, 14'h0020, 14'h0002, 8, 4'd6, 4'd5, 4'd1, 3'b111, 3'b000};
      tbl[6] = '{10'h201, 14'h0400, 14'h0001, 8, 4'd0, 4'd0, 4'd0, 3'b001, 3'b110};

      rst_n = 1'b0; start = 1'b0; clear = 1'b0;
      IO_north_i = '0; IO_east_i = '0; IO_west_i = '0;
      b_start = 1'b0; b_clear = 1'b0; b_north = '0; b_east = '0; b_west = '0;
      model_reset();
      tick(); tick();
      check("reset_a", 32'(pack_a()), 32'd0);
      check("reset_b", 32'(pack_b()), 32'd0);
      rst_n = 1'b1;
      tick();

      // Table of full identification runs
      for (int i = 0; i < 7; i++) begin
         IO_north_i = tbl[i].n; IO_east_i = tbl[i].e; IO_west_i = tbl[i].w;
         run_until_done(200, edges);
         check($sformatf("latency[%0d]", i), 32'(edges), 32'(tbl[i].lat));
         check($sformatf("result[%0d]", i),
               32'({north_id, east_id, west_id, north_vld, east_vld, west_vld,
                    north_err, east_err, west_err, timeout}),
               32'({tbl[i].nid, tbl[i].eid, tbl[i].wid, tbl[i].vld, tbl[i].err, 1'b0}));
      end

      // East toggles through settle and early CHECK, then holds
      IO_north_i = 10'h004; IO_west_i = 14'h0008; IO_east_i = 14'h0002;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         IO_east_i = (i % 2 == 1) ? 14'h0004 : 14'h0002;
         tick();
         if (done) check("stab_early_done", 32'(done), 32'd0);
      end
      IO_east_i = 14'h0004;
      edges = 0;
      while (!done && edges < 100) begin tick(); edges++; end
      check("stab_latency", 32'(edges), 32'd4);
      check("stab_east", 32'({east_id, east_vld, east_err, timeout}), 32'({4'd2, 1'b1, 1'b0, 1'b0}));

      // West never settles
      IO_north_i = 10'h004; IO_east_i = 14'h0001; IO_west_i = 14'h0002;
      start = 1'b1; tick(); start = 1'b0;
      edges = 0;
      while (!done && edges < 200) begin
         IO_west_i = (IO_west_i == 14'h0002) ? 14'h0004 : 14'h0002;
         tick(); edges++;
      end
      check("tmo_latency", 32'(edges), 32'(S + TO));
      check("tmo_result",
            32'({timeout, north_id, north_vld, east_id, east_vld, west_id, west_vld, west_err}),
            32'({1'b1, 4'd2, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0}));

      // start during CHECK is ignored
      IO_west_i = 14'h0008;
      start = 1'b1; tick(); start = 1'b0;
      repeat (6) tick();
      start = 1'b1; tick(); start = 1'b0;
      edges = 7;
      while (!done && edges < 200) begin tick(); edges++; end
      check("start_in_check", 32'(edges), 32'd8);

      // clear during SETTLE
      start = 1'b1; tick(); start = 1'b0;
      tick();
      clear = 1'b1; tick(); clear = 1'b0;
      check("clear_settle", 32'({busy, done}), 32'd0);
      tick();
      check("clear_stays_idle", 32'(pack_a()), 32'd0);

      // start and clear together in DONE
      run_until_done(200, edges);
      check("reach_done", 32'(done), 32'd1);
      start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
      check("done_start_clear", 32'(pack_a()), 32'd0);

      // asynchronous reset mid-CHECK
      start = 1'b1; tick(); start = 1'b0;
      repeat (6) tick();
      check("in_check_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("async_reset", 32'(pack_a()), 32'd0);
      model_reset();
      #1 rst_n = 1'b1;
      tick();

      // Minimum settle and stability on the second instance
      b_north = 10'h100; b_east = 14'h0001; b_west = 14'h0010;
      b_start = 1'b1; tick(); b_start = 1'b0;
      edges = 0;
      while (!b_done && edges < 50) begin tick(); edges++; end
      check("bnd_latency", 32'(edges), 32'd3);
      check("bnd_result", 32'({b_north_id, b_north_vld, b_east_id, b_west_id, b_timeout}),
            32'({4'd8, 1'b1, 4'd0, 4'd4, 1'b0}));

      // Randomized traffic checked each cycle against the model
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(7) == 0) begin tmp = rand_pat(10); IO_north_i = tmp[9:0]; end
         if ($urandom_range(7) == 0) IO_east_i = rand_pat(14);
         if ($urandom_range(7) == 0) IO_west_i = rand_pat(14);
         start = ($urandom_range(9) == 0);
         clear = ($urandom_range(79) == 0);
         tick();
      end
      start = 1'b0; clear = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
